// File: rtl/t_inst_ab.sv
// t_inst_ab: pass-through, inverted and one-cycle registered paths, plus trace-only inputs.
module t_inst_ab (
   input  logic          clk,
   input  logic          reset,
   input  logic [4:0]    i_w5,
   input  logic [39:0]   i_w40,
   input  logic [103:0]  i_w104,
   input  logic          i_seq,
   input  logic          i_com,
   input  logic [15:14]  i2_com,
   input  logic [127:0]  wide_for_trace,
   input  logic [127:0]  wide_for_trace_2,
   output logic [4:0]    o_w5,
   output logic [4:0]    o_w5_d1r,
   output logic [39:0]   o_w40,
   output logic [103:0]  o_w104,
   output logic          o_seq_d1r,
   output logic          o_com,
   output logic [15:14]  o2_com
);
   logic [4:0] r_w5;
   logic       r_seq;
   logic       w_unused_trace;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w5  <= '0;
         r_seq <= 1'b0;
      end else begin
         r_w5  <= i_w5;
         r_seq <= ~i_seq;
      end
   end
   assign o_w5      = i_w5;
   assign o_w40     = i_w40;
   assign o_w104    = i_w104;
   assign o_w5_d1r  = r_w5;
   assign o_seq_d1r = r_seq;
   assign o_com     = ~i_com;
   assign o2_com    = ~i2_com;
   // trace vectors stay on the port list for waveform visibility only
   assign w_unused_trace = ^{wide_for_trace, wide_for_trace_2};
endmodule

// File: tb/tb_t_inst_ab.sv
// tb_t_inst_ab: randomized and directed checks of t_inst_ab against a behavioural model.
`timescale 1ns/1ps
module tb_t_inst_ab;
   logic          clk = 1'b0, fclk = 1'b0, reset;
   logic [4:0]    i_w5, o_w5, o_w5_d1r;
   logic [39:0]   i_w40, o_w40;
   logic [103:0]  i_w104, o_w104;
   logic          i_seq, i_com, o_seq_d1r, o_com;
   logic [15:14]  i2_com, o2_com;
   logic [127:0]  wide_for_trace, wide_for_trace_2;
   int            checks = 0, errors = 0;
   logic [4:0]    exp_w5_d1r;
   logic          exp_seq_d1r;

   t_inst_ab dut (
      .clk(clk), .reset(reset), .i_w5(i_w5), .i_w40(i_w40), .i_w104(i_w104),
      .i_seq(i_seq), .i_com(i_com), .i2_com(i2_com),
      .wide_for_trace(wide_for_trace), .wide_for_trace_2(wide_for_trace_2),
      .o_w5(o_w5), .o_w5_d1r(o_w5_d1r), .o_w40(o_w40), .o_w104(o_w104),
      .o_seq_d1r(o_seq_d1r), .o_com(o_com), .o2_com(o2_com)
   );

   always #5 clk = ~clk;
   always #2 fclk = ~fclk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_comb(input string tag);
      check({tag, ".o_w5"}, o_w5, i_w5);
      check({tag, ".o_w40"}, o_w40, i_w40);
      check({tag, ".o_w40_top"}, o_w40[39:32], i_w40[39:32]);
      check({tag, ".o_w104"}, o_w104, i_w104);
      check({tag, ".o_com"}, o_com, 1'(~i_com));
      check({tag, ".o2_com"}, o2_com, 2'(~i2_com));
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".o_w5_d1r"}, o_w5_d1r, exp_w5_d1r);
      check({tag, ".o_seq_d1r"}, o_seq_d1r, exp_seq_d1r);
   endtask

   // model of the registered paths: load on edge, reset wins
   task automatic tick();
      exp_w5_d1r  = reset ? 5'd0 : i_w5;
      exp_seq_d1r = reset ? 1'b0 : ~i_seq;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] r;
      reset = 1'b1; i_w5 = '0; i_w40 = '0; i_w104 = '0; i_seq = 1'b0;
      i_com = 1'b0; i2_com = 2'b00; wide_for_trace = '0; wide_for_trace_2 = '0;
      tick(); tick();
      check_regs("reset");
      check_comb("reset_comb");

      reset = 1'b0;
      i_w5 = 5'b10110; i_w40 = 40'h0a0b0c0d0e; i_w104 = 104'h0f_0000_0000_0abc_abcd_7654_3210;
      #1 check_comb("passthru");

      i_w5 = 5'b00000; tick();
      check("w5_before", o_w5_d1r, 5'b00000);
      i_w5 = 5'b10110; #1 check("w5_pre_edge", o_w5_d1r, 5'b00000);
      tick(); check("w5_after", o_w5_d1r, 5'b10110);

      i_seq = 1'b1; tick(); check("seq_hi", o_seq_d1r, 1'b0);
      i_seq = 1'b0; tick(); check("seq_lo", o_seq_d1r, 1'b1);

      i_com = 1'b1; i2_com = 2'b10;
      repeat (3) begin @(posedge fclk); check("fast_com1", o_com, 1'b0); check("fast_i2com1", o2_com, 2'b01); end
      i_com = 1'b0; i2_com = 2'b01;
      repeat (3) begin @(posedge fclk); check("fast_com0", o_com, 1'b1); check("fast_i2com0", o2_com, 2'b10); end
      @(posedge clk); #1;

      reset = 1'b1; i_seq = 1'b1; i_w5 = 5'h1F;
      tick(); tick();
      check("rst_w5_d1r", o_w5_d1r, 5'd0);
      check("rst_seq_d1r", o_seq_d1r, 1'b0);
      check("rst_o_w5", o_w5, 5'h1F);
      reset = 1'b0; i_seq = 1'b0;
      #1 check("rst_hold", o_w5_d1r, 5'd0);
      tick();
      check("rel_w5_d1r", o_w5_d1r, 5'h1F);
      check("rel_seq_d1r", o_seq_d1r, 1'b1);

      wide_for_trace = 128'h1234_5678_aaaa_bbbb_cccc_dddd;
      for (int k = 0; k < 8; k++) begin
         wide_for_trace_2 = rnd128();
         #1 check_comb("trace");
         check_regs("trace_regs");
      end

      for (int n = 0; n < 300; n++) begin
         reset = ($urandom_range(0, 9) == 0);
         i_w5 = 5'($urandom); i_w40 = {8'($urandom), $urandom};
         r = rnd128(); i_w104 = r[103:0];
         i_seq = 1'($urandom); i_com = 1'($urandom); i2_com = 2'($urandom);
         wide_for_trace = rnd128(); wide_for_trace_2 = rnd128();
         #1 check_comb("rand");
         tick();
         check_regs("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
